bus_arbiter: RTL
================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter PRIO_MODE, default 0, 0 = round-robin between requesters, 1 = fixed priority to requester 0.
REQ-002 Parameter TIMEOUT, default 16, maximum WAIT cycles before a forced error completion; 0 disables the timeout.
REQ-003 PCLK  input  1  single clock; all state updates on the rising edge.
REQ-004 PRESET  input  1  asynchronous, active-high reset.
REQ-005 m0_req / m1_req  input  1 each  request, held high with the command fields stable until the matching mN_ready.
REQ-006 m0_write / m1_write  input  1 each  1 = write, 0 = read.
REQ-007 m0_addr / m1_addr, m0_wdata / m1_wdata  input  32 each  address and write data.
REQ-008 m0_ready / m1_ready  output  1 each  one-cycle completion pulse.
REQ-009 m0_err / m1_err  output  1 each  high together with mN_ready when the completion is a timeout.
REQ-010 m0_rdata / m1_rdata  output  32 each  read data, valid while mN_ready is high.
REQ-011 transfer  output  1  one-cycle start pulse to the APB master.
REQ-012 write  output  1, addr  output  32, wdata  output  32  command to the APB master.
REQ-013 ready  input  1, rdata  input  32  completion and read data from the APB master.
REQ-014 grant  output  2  one-hot owner (bit0 = m0, bit1 = m1), 00 when IDLE.
REQ-015 busy  output  1  high in ISSUE and WAIT.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, ISSUE and WAIT.
REQ-017 IDLE: if any mN_req is high, the winner SHALL be latched into grant and the FSM SHALL move to ISSUE on the next edge; otherwise it stays in IDLE.
REQ-018 Round-robin (PRIO_MODE=0): when both requests are high, the requester not granted last SHALL win; with a single request, that requester SHALL win.
REQ-019 Fixed priority (PRIO_MODE=1): m0 SHALL win whenever m0_req is high.
REQ-020 ISSUE: transfer SHALL be 1 for exactly one cycle, the timeout counter SHALL be cleared, and the FSM SHALL move to WAIT.
REQ-021 write/addr/wdata SHALL be muxed from the granted requester in ISSUE and WAIT, and SHALL be 0 in IDLE.
REQ-022 WAIT, ready=1: the granted mN_ready SHALL be 1 combinationally in the same cycle, with mN_rdata = rdata and mN_err = 0; last-granted SHALL update and the FSM SHALL return to IDLE.
REQ-023 WAIT, ready=0: the counter SHALL increment; if TIMEOUT is nonzero and the counter equals TIMEOUT-1, then mN_ready = 1, mN_err = 1, mN_rdata = 0 for that cycle, last-granted SHALL update, and the FSM SHALL return to IDLE.
REQ-024 If ready and the timeout condition occur in the same cycle, ready SHALL take precedence (err = 0).
REQ-025 The counter SHALL be $clog2(TIMEOUT+1) bits wide and saturate rather than wrap; with TIMEOUT=0 WAIT lasts until ready.
REQ-026 The non-granted requester's ready, err and rdata SHALL be 0 at all times; ready is ignored outside WAIT.
REQ-027 A requester dropping req before its ready SHALL NOT abort the transfer; completion is still signalled.
REQ-028 Minimum latency from req rising in IDLE to mN_ready SHALL be 3 cycles (IDLE, ISSUE, WAIT with ready=1).

Reset
REQ-029 On PRESET, the FSM SHALL enter IDLE immediately.
REQ-030 On PRESET, all outputs SHALL be 0, the counter SHALL be 0, and last-granted SHALL be m1 so that m0 wins the first tie.
REQ-031 Reset asserted in ISSUE or WAIT SHALL abandon the transfer with no mN_ready pulse; after release, pending requests re-arbitrate from IDLE.

Verification
REQ-032 m0 write, addr 0x1000_2000, wdata 0xA5, ready one cycle after transfer -> one transfer pulse with write=1, addr 0x1000_2000, wdata 0xA5; m0_ready pulse 3 cycles after req; m0_err = 0.
REQ-033 m0 and m1 continuously requesting, PRIO_MODE=0 -> grant sequence m0, m1, m0, m1; no starvation.
REQ-034 Same stimulus, PRIO_MODE=1 -> grant stays m0 while m0_req is high; m1 is served only after m0 drops req.
REQ-035 m1 read, TIMEOUT=4, ready never asserted -> m1_ready = m1_err = 1 and m1_rdata = 0 on the 4th WAIT cycle; FSM back in IDLE.
REQ-036 m1 read with rdata 0xDEADBEEF, ready and timeout in the same cycle -> m1_rdata = 0xDEADBEEF, m1_err = 0.
REQ-037 PRESET pulsed during WAIT -> outputs 0 immediately, no ready pulse; after release, a held m0 request is issued again.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-requester arbiter in front of a single APB master.
// Latency: req in IDLE -> transfer next cycle -> mN_ready no earlier than the third cycle.
// Backpressure: requesters hold req until their ready; WAIT lasts until APB ready or timeout.
//
// Ports:
//   PCLK, PRESET            clock, asynchronous active-high reset
//   mN_req/write/addr/wdata requester command (N = 0, 1)
//   mN_ready/err/rdata      requester completion (err marks a timeout completion)
//   transfer/write/addr/wdata  command to the APB master; ready/rdata back from it
//   grant                   one-hot current owner, busy high during ISSUE and WAIT
module bus_arbiter #(
  parameter int PRIO_MODE = 0,
  parameter int TIMEOUT   = 16
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        m0_req,
  input  logic        m0_write,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ready,
  output logic        m0_err,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_write,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ready,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  output logic        transfer,
  output logic        write,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic        ready,
  input  logic [31:0] rdata,
  output logic [1:0]  grant,
  output logic        busy
);

  // A zero-width counter is illegal, so TIMEOUT=0 keeps a 1-bit counter that never matters.
  localparam int            CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int            LAST_I   = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
  localparam logic [CW-1:0] CNT_LAST = LAST_I[CW-1:0];
  localparam bit            TO_EN    = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t        state_q;
  logic [1:0]    grant_q;
  logic          transfer_q;
  logic          busy_q;
  logic          last_q;      // 1 = m1 was granted last
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          win_m1_d;
  logic          done_ok;
  logic          done_to;
  logic          done;

  always_comb begin
    cnt_d    = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);
    win_m1_d = 1'b0;
    if (PRIO_MODE == 1) begin
      win_m1_d = !m0_req;
    end else begin
      // m1 wins alone, or on a tie when m0 was the previous owner.
      win_m1_d = m1_req && (!m0_req || !last_q);
    end
  end

  // Ready beats a coincident timeout because done_to requires ready low.
  assign done_ok = (state_q == WAIT) && ready;
  assign done_to = (state_q == WAIT) && !ready && TO_EN && (cnt_q == CNT_LAST);
  assign done    = done_ok || done_to;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q    <= IDLE;
      grant_q    <= 2'b00;
      transfer_q <= 1'b0;
      busy_q     <= 1'b0;
      last_q     <= 1'b1;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (m0_req || m1_req) begin
            grant_q    <= win_m1_d ? 2'b10 : 2'b01;
            transfer_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          transfer_q <= 1'b0;
          cnt_q      <= '0;
          state_q    <= WAIT;
        end
        WAIT: begin
          if (done) begin
            last_q  <= grant_q[1];
            grant_q <= 2'b00;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          grant_q    <= 2'b00;
          transfer_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  // grant_q is zero in IDLE, so the command mux and completions fall to zero there.
  assign transfer = transfer_q;
  assign busy     = busy_q;
  assign grant    = grant_q;
  assign write    = (grant_q[0] && m0_write) || (grant_q[1] && m1_write);
  assign addr     = grant_q[0] ? m0_addr  : (grant_q[1] ? m1_addr  : 32'h0);
  assign wdata    = grant_q[0] ? m0_wdata : (grant_q[1] ? m1_wdata : 32'h0);

  assign m0_ready = grant_q[0] && done;
  assign m1_ready = grant_q[1] && done;
  assign m0_err   = grant_q[0] && done_to;
  assign m1_err   = grant_q[1] && done_to;
  assign m0_rdata = (grant_q[0] && done_ok) ? rdata : 32'h0;
  assign m1_rdata = (grant_q[1] && done_ok) ? rdata : 32'h0;

endmodule
